// File: rtl/adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter
//   Shares one W-bit ripple-carry adder between NREQ requesters. A round-robin
//   arbiter grants at most one request per cycle. The granted operands go
//   through the adder, and the sum is captured in a one-entry result register
//   that the consumer drains through a valid/ready port.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req[NREQ]          per-requester request
//   req_a, req_b       per-requester operands, requester i in bits [i*W +: W]
//   req_cin[NREQ]      per-requester carry-in
//   gnt[NREQ]          one-hot grant (combinational); operands captured this edge
//   res_valid          result register holds an unconsumed result
//   res_ready          consumer takes the result on this edge when res_valid=1
//   res_id             index of the requester that owns the result
//   res_sum, res_carry A+B+cin (low W bits) and carry-out
//   dbg_state          FSM state (0 = EMPTY, 1 = FULL)
//
// Handshake (result port): a result transfers on a rising edge where
// res_valid=1 and res_ready=1. While res_valid=1 and res_ready=0, res_id,
// res_sum and res_carry hold steady. A new grant may load the slot on the
// same edge that drains it, which gives one operation per cycle.
// -----------------------------------------------------------------------------
module adder_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic [NREQ-1:0]   gnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [W-1:0]      res_sum,
  output logic              res_carry,
  output logic              dbg_state
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;

  logic           slot_free;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic [W-1:0]   op_a, op_b;
  logic           op_cin;
  logic [W-1:0]   sum_c;
  logic [W:0]     carry_c;

  // Index (base + k) modulo NREQ. This works for non-power-of-two NREQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NREQ;
    return IDW'(s);
  endfunction

  assign slot_free = (state_q == ST_EMPTY) || res_ready;

  // Round-robin search that starts one past the last granted requester.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = wrap_idx(last_q, k);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    // No grant while the slot is blocked or while reset is held.
    if (!rst_n || !slot_free) begin
      gnt_any = 1'b0;
    end
  end

  assign gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  // Operand mux that feeds the shared adder.
  assign op_a   = req_a[int'(gnt_idx)*W +: W];
  assign op_b   = req_b[int'(gnt_idx)*W +: W];
  assign op_cin = req_cin[gnt_idx];

  // Ripple-carry chain of full-adder cells.
  always_comb begin
    sum_c      = '0;
    carry_c    = '0;
    carry_c[0] = op_cin;
    for (int i = 0; i < W; i++) begin
      sum_c[i]     = op_a[i] ^ op_b[i] ^ carry_c[i];
      carry_c[i+1] = (op_a[i] & op_b[i]) | (carry_c[i] & (op_a[i] ^ op_b[i]));
    end
  end

  // Next-state logic for the FSM and the result register.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      ST_EMPTY: if (gnt_any) state_d = ST_FULL;
      ST_FULL:  if (res_ready && !gnt_any) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (gnt_any) begin
      last_d  = gnt_idx;
      id_d    = gnt_idx;
      sum_d   = sum_c;
      carry_d = carry_c[W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_id    = id_q;
  assign res_sum   = sum_q;
  assign res_carry = carry_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_rr_arbiter
//   Directed bench for adder_rr_arbiter (NREQ=4, W=8). It changes inputs 1 ns
//   after a rising edge, samples the combinational grant 1 ns later, and
//   samples registered outputs 1 ns after the next rising edge.
// -----------------------------------------------------------------------------
module tb_adder_rr_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   gnt;
  logic              res_valid, res_ready, res_carry, dbg_state;
  logic [IDW-1:0]    res_id;
  logic [W-1:0]      res_sum;

  always #5 clk = ~clk;

  adder_rr_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_sum(res_sum), .res_carry(res_carry),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [IDW+W:0] exp_q[$];   // {id, carry, sum}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [IDW-1:0] id,
                           input logic [W-1:0] sum, input logic carry);
    check({tag, "_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_id"},    32'(res_id),    32'(id));
    check({tag, "_sum"},   32'(res_sum),   32'(sum));
    check({tag, "_carry"}, 32'(res_carry), 32'(carry));
  endtask

  // Request lines of an idle requester must never be X.
  always @(negedge clk) begin
    if (rst_n === 1'b1) check("req_known", 32'($isunknown(req)), 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [IDW+W:0] e;
    rst_n = 1'b0; req = '0; req_a = '0; req_b = '0; req_cin = '0; res_ready = 1'b0;

    // Reset state
    #3;
    check("rst_valid", 32'(res_valid), 0);
    check("rst_id",    32'(res_id),    0);
    check("rst_sum",   32'(res_sum),   0);
    check("rst_carry", 32'(res_carry), 0);
    check("rst_gnt",   32'(gnt),       0);
    check("rst_state", 32'(dbg_state), 0);
    tick();
    rst_n = 1'b1;

    // 1: single request from requester 0
    set_op(0, 8'h12, 8'h34, 1'b0);
    req = 4'b0001;
    #1 check("t1_gnt", 32'(gnt), 32'b0001);
    tick();
    req = '0;
    #1 check_res("t1", 2'd0, 8'h46, 1'b0);
    check("t1_gnt_idle", 32'(gnt), 0);

    // 2: overflow with carry-in, 0xFF+0x01+1
    set_op(1, 8'hFF, 8'h01, 1'b1);
    req = 4'b0010; res_ready = 1'b1;
    #1 check("t2_gnt", 32'(gnt), 32'b0010);
    tick();
    req = '0;
    #1 check_res("t2", 2'd1, 8'h01, 1'b1);
    tick();
    #1 check("t2_drained", 32'(res_valid), 0);

    // Reset again so the pointer starts at NREQ-1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // 3: all requesting, full throughput, round-robin order
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(16 * (i + 1)), 8'(i + 1), 1'b0);
    req = 4'b1111; res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 check("t3_gnt", 32'(gnt), 32'(1) << (k % 4));
      if (k > 0) begin
        e = exp_q.pop_front();
        check("t3_res", {21'b0, res_valid, res_id, res_carry, res_sum}, {21'b0, 1'b1, e});
      end
      // Requester i: 16*(i+1) + (i+1) = 0x11*(i+1)
      exp_q.push_back({2'(k % 4), 1'b0, 8'(17 * ((k % 4) + 1))});
      tick();
    end
    req = '0;
    #1 check("t3_gnt_off", 32'(gnt), 0);
    e = exp_q.pop_front();
    check("t3_res_last", {21'b0, res_valid, res_id, res_carry, res_sum}, {21'b0, 1'b1, e});
    check("t3_q_empty", 32'(exp_q.size()), 0);
    tick();
    #1 check("t3_drained", 32'(res_valid), 0);

    // 4: backpressure holds the result and blocks grants
    set_op(0, 8'h12, 8'h34, 1'b0);
    set_op(2, 8'h20, 8'h05, 1'b1);
    res_ready = 1'b0; req = 4'b0001;
    #1 check("t4_gnt0", 32'(gnt), 32'b0001);
    tick();
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1 check("t4_blocked", 32'(gnt), 0);
      check_res("t4_hold", 2'd0, 8'h46, 1'b0);
      tick();
    end
    res_ready = 1'b1;
    #1 check("t4_gnt2", 32'(gnt), 32'b0100);
    tick();
    req = '0;
    #1 check_res("t4", 2'd2, 8'h26, 1'b0);
    tick();

    // 5: fairness after skip (last=1, req=1001 -> 3 then 0)
    set_op(1, 8'hFF, 8'h01, 1'b1);
    req = 4'b0010;
    #1 check("t5_gnt1", 32'(gnt), 32'b0010);
    tick();
    set_op(3, 8'h40, 8'h04, 1'b0);
    req = 4'b1001;
    #1 check_res("t5_r1", 2'd1, 8'h01, 1'b1);
    check("t5_gnt3", 32'(gnt), 32'b1000);
    tick();
    #1 check_res("t5_r3", 2'd3, 8'h44, 1'b0);
    check("t5_gnt0", 32'(gnt), 32'b0001);
    tick();
    req = '0; res_ready = 1'b0;
    #1 check_res("t5_r0", 2'd0, 8'h46, 1'b0);
    // Withdrawn request: req2 pulses while the slot is blocked
    req = 4'b0100;
    #1 check("t5_wd_gnt", 32'(gnt), 0);
    tick();
    req = '0; res_ready = 1'b1;
    #1 check("t5_wd_gnt2", 32'(gnt), 0);
    check_res("t5_wd_hold", 2'd0, 8'h46, 1'b0);
    tick();
    #1 check("t5_wd_empty", 32'(res_valid), 0);
    tick();
    #1 check("t5_wd_noresult", 32'(res_valid), 0);

    // 6: reset while a result is pending
    req = 4'b1111; res_ready = 1'b0;
    #1 check("t6_gnt1", 32'(gnt), 32'b0010);
    tick();
    check("t6_full", 32'(res_valid), 1);
    rst_n = 1'b0;
    #1 check("t6_rst_valid", 32'(res_valid), 0);
    check("t6_rst_gnt", 32'(gnt), 0);
    tick();
    rst_n = 1'b1;
    #1 check("t6_first_gnt", 32'(gnt), 32'b0001);
    tick();
    req = '0;
    #1 check_res("t6", 2'd0, 8'h46, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
